// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin write-port arbiter for the register file.
// Define RF_ARB_STATS_EN to add a saturating conflict counter on stat_conflicts.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,

    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]       stat_conflicts
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;

    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              pick_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // B wins when it is alone, or on a tie when A took the previous grant.
    assign pick_b   = b_req && (!a_req || (last_grant_q == GRANT_A));
    assign sel_addr = pick_b ? b_addr : a_addr;
    assign sel_data = pick_b ? b_data : a_data;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        we_d         = 1'b0;
        busy_d       = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d      = WRITE;
                    busy_d       = 1'b1;
                    waddr_d      = sel_addr;
                    wdata_d      = sel_data;
                    we_d         = (sel_addr != '0);
                    a_ack_d      = !pick_b;
                    b_ack_d      = pick_b;
                    last_grant_d = pick_b ? GRANT_B : GRANT_A;
                end
            end
            WRITE: begin
                // Requests are ignored here; the requester re-presents at this edge.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_B;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Qualifying the strobes with resetn aborts a write whose WRITE cycle
    // coincides with reset: neither the register file nor the requester sees it.
    assign a_ack    = a_ack_q & resetn;
    assign b_ack    = b_ack_q & resetn;
    assign rf_we    = we_q    & resetn;
    assign busy     = busy_q  & resetn;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

`ifdef RF_ARB_STATS_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            conflict_cnt <= '0;
        end else if ((state_q == IDLE) && a_req && b_req && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign stat_conflicts = conflict_cnt;
`endif

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width in bits (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 a_req  input  1  requester A (ALU writeback) write request; held high with a_addr/a_data stable until a_ack.
REQ-006 a_addr  input  ADDR_W  requester A destination register.
REQ-007 a_data  input  DATA_W  requester A write data.
REQ-008 a_ack  output  1  one-cycle pulse, requester A write accepted.
REQ-009 b_req  input  1  requester B (load unit) write request; same rules as a_req.
REQ-010 b_addr  input  ADDR_W  requester B destination register.
REQ-011 b_data  input  DATA_W  requester B write data.
REQ-012 b_ack  output  1  one-cycle pulse, requester B write accepted.
REQ-013 rf_we  output  1  register file write enable, one-cycle pulse per accepted non-x0 write.
REQ-014 rf_waddr  output  ADDR_W  register file write address, valid while rf_we high.
REQ-015 rf_wdata  output  DATA_W  register file write data, valid while rf_we high.
REQ-016 busy  output  1  high while FSM is in WRITE.
REQ-017 stat_conflicts  output  16  conflict count; present only when RF_ARB_STATS_EN is defined.

Function
REQ-018 FSM SHALL have two states: IDLE and WRITE; all outputs registered.
REQ-019 In IDLE with any req high, the block SHALL grant one requester, latch its addr/data, and enter WRITE on the next edge.
REQ-020 In WRITE, the block SHALL drive the granted ack high for exactly that cycle, drive rf_we high for that cycle unless latched addr is 0, then return to IDLE.
REQ-021 Latency: req sampled high in IDLE at edge N -> ack/rf_we high in the cycle after edge N; peak throughput one write per 2 cycles.
REQ-022 Requesters SHALL drop req or present a new request at the edge ending the ack cycle; arbiter ignores req during WRITE.
REQ-023 Single req high: that requester is granted regardless of priority pointer.
REQ-024 Both req high in IDLE: grant the requester not granted last (round-robin); last_grant pointer updates on every grant.
REQ-025 Write to address 0: ack issued normally, rf_we stays 0, rf_waddr/rf_wdata still show latched values.
REQ-026 Both requesters targeting the same address: serialised by round-robin; second write lands last and wins.
REQ-027 rf_waddr/rf_wdata SHALL hold last latched values outside WRITE.

Reset
REQ-028 resetn low at a clock edge SHALL force IDLE, a_ack=0, b_ack=0, rf_we=0, busy=0, rf_waddr=0, rf_wdata=0, last_grant=B (A wins first tie), stat_conflicts=0.
REQ-029 Reset asserted during WRITE SHALL abort the write: no rf_we, no ack; requester re-issues after reset.

Configuration
REQ-030 Macro RF_ARB_STATS_EN defined: 16-bit counter increments each cycle in IDLE with a_req and b_req both high, saturates at 0xFFFF, drives stat_conflicts.
REQ-031 Macro RF_ARB_STATS_EN undefined: counter and stat_conflicts port absent; all other behaviour identical.

Verification
REQ-032 Reset, then a_req=1, a_addr=5, a_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, a_ack=1, busy=1; following cycle all low.
REQ-033 After reset, a_req=b_req=1 held continuously (addr 3/4) -> grants A,B,A,B on alternate cycles; acks never coincide.
REQ-034 b_req=1, b_addr=0, b_data=0x12345678 -> b_ack=1, rf_we=0 in the ack cycle.
REQ-035 a_req=1 addr 7; resetn=0 in the WRITE cycle -> no rf_we, no a_ack; FSM in IDLE, all outputs 0 after reset.
REQ-036 With RF_ARB_STATS_EN, 3 conflict cycles in IDLE -> stat_conflicts=3; forced 70000 conflicts -> stat_conflicts=0xFFFF.
